// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the RV32I instruction-decode/control stage:
// opcode constants, ALU operation codes and the packed control bundle.
// The bundle is carried by the main and skid registers and consumed by execute.
package ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J_JAL   = 7'b1101111;
  localparam logic [6:0] OP_CSR     = 7'b1110011;

  // funct7 values that select base, alternate and M-extension R-type ops
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // Native width of the ALU code inside the bundle
  localparam int ALU_W = 5;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_ADD    = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_SUB    = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_SLL    = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SLT    = 5'b10111;
  localparam logic [ALU_W-1:0] ALU_SLTU   = 5'b11000;
  localparam logic [ALU_W-1:0] ALU_XOR    = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_SRL    = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_SRA    = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_OR     = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_AND    = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_MUL    = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_MULH   = 5'b01001;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 5'b01010;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 5'b01011;
  localparam logic [ALU_W-1:0] ALU_DIV    = 5'b01100;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 5'b01101;
  localparam logic [ALU_W-1:0] ALU_REM    = 5'b01110;
  localparam logic [ALU_W-1:0] ALU_REMU   = 5'b01111;

  // Decoded control bundle; register fields are passed through raw
  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             regwrite;
    logic             alusrc;
    logic             memwrite;
    logic             memtoreg;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             auipc;
    logic             lui;
    logic             csr;
    logic [ALU_W-1:0] aluctrl;
    logic             illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decoder: raw instruction in, control bundle out.
// Undefined encodings raise the illegal flag and zero every control bit.
// Build option: define RV_M_EXT_EN to decode the M extension (funct7 0000001);
// otherwise those R-type encodings decode as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decode opcode/funct fields, then apply illegal and rd=x0 overrides
  always_comb begin
    bundle        = '0;
    bundle.rd     = instr[11:7];
    bundle.rs1    = instr[19:15];
    bundle.rs2    = instr[24:20];
    bundle.funct3 = funct3;

    case (opcode)
      OP_R: begin
        bundle.regwrite = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: bundle.aluctrl = ALU_ADD;
          {F7_ALT,  3'b000}: bundle.aluctrl = ALU_SUB;
          {F7_BASE, 3'b001}: bundle.aluctrl = ALU_SLL;
          {F7_BASE, 3'b010}: bundle.aluctrl = ALU_SLT;
          {F7_BASE, 3'b011}: bundle.aluctrl = ALU_SLTU;
          {F7_BASE, 3'b100}: bundle.aluctrl = ALU_XOR;
          {F7_BASE, 3'b101}: bundle.aluctrl = ALU_SRL;
          {F7_ALT,  3'b101}: bundle.aluctrl = ALU_SRA;
          {F7_BASE, 3'b110}: bundle.aluctrl = ALU_OR;
          {F7_BASE, 3'b111}: bundle.aluctrl = ALU_AND;
`ifdef RV_M_EXT_EN
          {F7_MEXT, 3'b000}: bundle.aluctrl = ALU_MUL;
          {F7_MEXT, 3'b001}: bundle.aluctrl = ALU_MULH;
          {F7_MEXT, 3'b010}: bundle.aluctrl = ALU_MULHSU;
          {F7_MEXT, 3'b011}: bundle.aluctrl = ALU_MULHU;
          {F7_MEXT, 3'b100}: bundle.aluctrl = ALU_DIV;
          {F7_MEXT, 3'b101}: bundle.aluctrl = ALU_DIVU;
          {F7_MEXT, 3'b110}: bundle.aluctrl = ALU_REM;
          {F7_MEXT, 3'b111}: bundle.aluctrl = ALU_REMU;
`endif
          default:           bundle.illegal = 1'b1;
        endcase
      end

      OP_I_ARITH: begin
        bundle.regwrite = 1'b1;
        bundle.alusrc   = 1'b1;
        case (funct3)
          3'b000: bundle.aluctrl = ALU_ADD;
          3'b010: bundle.aluctrl = ALU_SLT;
          3'b011: bundle.aluctrl = ALU_SLTU;
          3'b100: bundle.aluctrl = ALU_XOR;
          3'b110: bundle.aluctrl = ALU_OR;
          3'b111: bundle.aluctrl = ALU_AND;
          3'b001: begin
            // slli: upper immediate bits must be zero
            if (funct7 == F7_BASE) bundle.aluctrl = ALU_SLL;
            else                   bundle.illegal = 1'b1;
          end
          default: begin
            // srli / srai share funct3 101 and differ in funct7
            if (funct7 == F7_BASE)     bundle.aluctrl = ALU_SRL;
            else if (funct7 == F7_ALT) bundle.aluctrl = ALU_SRA;
            else                       bundle.illegal = 1'b1;
          end
        endcase
      end

      OP_I_LOAD: begin
        bundle.regwrite = 1'b1;
        bundle.alusrc   = 1'b1;
        bundle.memtoreg = 1'b1;
        bundle.aluctrl  = ALU_ADD;
      end

      OP_I_JALR: begin
        bundle.regwrite = 1'b1;
        bundle.alusrc   = 1'b1;
        bundle.jalr     = 1'b1;
        bundle.aluctrl  = ALU_ADD;
      end

      OP_S: begin
        bundle.alusrc   = 1'b1;
        bundle.memwrite = 1'b1;
        bundle.aluctrl  = ALU_ADD;
      end

      OP_B: begin
        bundle.branch  = 1'b1;
        bundle.aluctrl = ALU_SUB;
      end

      OP_U_LUI: begin
        bundle.regwrite = 1'b1;
        bundle.alusrc   = 1'b1;
        bundle.lui      = 1'b1;
        bundle.aluctrl  = ALU_ADD;
      end

      OP_U_AUIPC: begin
        bundle.regwrite = 1'b1;
        bundle.auipc    = 1'b1;
        bundle.aluctrl  = ALU_ADD;
      end

      OP_J_JAL: begin
        bundle.regwrite = 1'b1;
        bundle.alusrc   = 1'b1;
        bundle.jal      = 1'b1;
        bundle.aluctrl  = ALU_ADD;
      end

      OP_CSR: begin
        bundle.csr = 1'b1;
      end

      default: bundle.illegal = 1'b1;
    endcase

    // An illegal encoding must not steer the datapath
    if (bundle.illegal) begin
      bundle.regwrite = 1'b0;
      bundle.alusrc   = 1'b0;
      bundle.memwrite = 1'b0;
      bundle.memtoreg = 1'b0;
      bundle.branch   = 1'b0;
      bundle.jal      = 1'b0;
      bundle.jalr     = 1'b0;
      bundle.auipc    = 1'b0;
      bundle.lui      = 1'b0;
      bundle.csr      = 1'b0;
      bundle.aluctrl  = '0;
    end

    // x0 is hardwired to zero, so writes to it are suppressed here
    if (bundle.rd == 5'd0) bundle.regwrite = 1'b0;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode/control stage between fetch and execute.
// A main register (M) drives the outputs and a skid register (S) absorbs the
// one extra instruction that can arrive while downstream stalls, so in_ready
// depends only on S occupancy and never on out_ready.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid is held with stable payload until the transfer occurs.
// Build option: RV_M_EXT_EN enables M-extension decode in ctrl_decode.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALUCTRL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [2:0]           out_funct3,
  output logic                 out_regwrite,
  output logic                 out_alusrc,
  output logic                 out_memwrite,
  output logic                 out_memtoreg,
  output logic                 out_branch,
  output logic                 out_jal,
  output logic                 out_jalr,
  output logic                 out_auipc,
  output logic                 out_lui,
  output logic                 out_csr,
  output logic [ALUCTRL_W-1:0] out_aluctrl,
  output logic                 out_illegal,
  output logic [15:0]          illegal_cnt
);

  ctrl_bundle_t    dec_b;
  ctrl_bundle_t    m_b;
  ctrl_bundle_t    s_b;
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] s_pc;
  logic            m_valid;
  logic            s_valid;
  logic            accept;
  logic            deliver;
  logic            m_free;

  ctrl_decode u_decode (
    .instr  (in_instr),
    .bundle (dec_b)
  );

  assign in_ready = !s_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign deliver  = m_valid && out_ready;
  assign m_free   = !m_valid || deliver;

  // M/S occupancy and payload movement; reset and flush drop both entries
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_b     <= '0;
      s_b     <= '0;
      m_pc    <= '0;
      s_pc    <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (deliver && s_valid) begin
      // S refills M; no accept is possible while S is occupied
      m_b     <= s_b;
      m_pc    <= s_pc;
      s_valid <= 1'b0;
    end else if (accept && m_free) begin
      m_b     <= dec_b;
      m_pc    <= in_pc;
      m_valid <= 1'b1;
    end else if (accept) begin
      s_b     <= dec_b;
      s_pc    <= in_pc;
      s_valid <= 1'b1;
    end else if (deliver) begin
      m_valid <= 1'b0;
    end
  end

  // Saturating count of illegal bundles handed to execute
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (deliver && m_b.illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  // Unpack M onto the output ports, zero-extending the ALU code
  always_comb begin
    out_aluctrl              = '0;
    out_aluctrl[ALU_W-1:0]   = m_b.aluctrl;
  end

  assign out_valid    = m_valid;
  assign out_pc       = m_pc;
  assign out_rd       = m_b.rd;
  assign out_rs1      = m_b.rs1;
  assign out_rs2      = m_b.rs2;
  assign out_funct3   = m_b.funct3;
  assign out_regwrite = m_b.regwrite;
  assign out_alusrc   = m_b.alusrc;
  assign out_memwrite = m_b.memwrite;
  assign out_memtoreg = m_b.memtoreg;
  assign out_branch   = m_b.branch;
  assign out_jal      = m_b.jal;
  assign out_jalr     = m_b.jalr;
  assign out_auipc    = m_b.auipc;
  assign out_lui      = m_b.lui;
  assign out_csr      = m_b.csr;
  assign out_illegal  = m_b.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed decode cases, backpressure,
// flush, a random-backpressure stream, illegal counter saturation and reset.
module tb_id_ctrl_stage;

  localparam int XLEN = 32;
  localparam int ALUCTRL_W = 5;
  localparam int N_INS = 19;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [2:0]           out_funct3;
  logic                 out_regwrite;
  logic                 out_alusrc;
  logic                 out_memwrite;
  logic                 out_memtoreg;
  logic                 out_branch;
  logic                 out_jal;
  logic                 out_jalr;
  logic                 out_auipc;
  logic                 out_lui;
  logic                 out_csr;
  logic [ALUCTRL_W-1:0] out_aluctrl;
  logic                 out_illegal;
  logic [15:0]          illegal_cnt;

  id_ctrl_stage #(.XLEN(XLEN), .ALUCTRL_W(ALUCTRL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_funct3   (out_funct3),
    .out_regwrite (out_regwrite),
    .out_alusrc   (out_alusrc),
    .out_memwrite (out_memwrite),
    .out_memtoreg (out_memtoreg),
    .out_branch   (out_branch),
    .out_jal      (out_jal),
    .out_jalr     (out_jalr),
    .out_auipc    (out_auipc),
    .out_lui      (out_lui),
    .out_csr      (out_csr),
    .out_aluctrl  (out_aluctrl),
    .out_illegal  (out_illegal),
    .illegal_cnt  (illegal_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [65:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] ins_tbl [N_INS] = '{
    32'h00500093, 32'h40208033, 32'h022081B3, 32'h007302B3, 32'h407352B3,
    32'h007332B3, 32'h00812203, 32'h00312223, 32'h00208063, 32'h000000EF,
    32'h000100E7, 32'h12345337, 32'h00001397, 32'h300090F3, 32'h40109093,
    32'h4010D093, 32'h00000000, 32'h407312B3, 32'hFFF34293
  };

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Hand-derived control words: {regwrite,alusrc,memwrite,memtoreg,branch,
  // jal,jalr,auipc,lui,csr, aluctrl[4:0], illegal}
  function automatic logic [15:0] ctl_of(input logic [31:0] ins);
    logic [15:0] c;
    case (ins)
      32'h00500093: c = {10'b1100000000, 5'b00000, 1'b0}; // addi x1,x0,5
      32'h40208033: c = {10'b0000000000, 5'b10000, 1'b0}; // sub x0,x1,x2
`ifdef RV_M_EXT_EN
      32'h022081B3: c = {10'b1000000000, 5'b01000, 1'b0}; // mul x3,x1,x2
`else
      32'h022081B3: c = 16'h0001;
`endif
      32'h007302B3: c = {10'b1000000000, 5'b00000, 1'b0}; // add
      32'h407352B3: c = {10'b1000000000, 5'b00110, 1'b0}; // sra
      32'h007332B3: c = {10'b1000000000, 5'b11000, 1'b0}; // sltu
      32'h00812203: c = {10'b1101000000, 5'b00000, 1'b0}; // lw
      32'h00312223: c = {10'b0110000000, 5'b00000, 1'b0}; // sw
      32'h00208063: c = {10'b0000100000, 5'b10000, 1'b0}; // beq
      32'h000000EF: c = {10'b1100010000, 5'b00000, 1'b0}; // jal
      32'h000100E7: c = {10'b1100001000, 5'b00000, 1'b0}; // jalr
      32'h12345337: c = {10'b1100000010, 5'b00000, 1'b0}; // lui
      32'h00001397: c = {10'b1000000100, 5'b00000, 1'b0}; // auipc
      32'h300090F3: c = {10'b0000000001, 5'b00000, 1'b0}; // csrrw
      32'h4010D093: c = {10'b1100000000, 5'b00110, 1'b0}; // srai
      32'hFFF34293: c = {10'b1100000000, 5'b00011, 1'b0}; // xori
      default:      c = 16'h0001; // slli bad funct7, 0x0, bad R funct7
    endcase
    return c;
  endfunction

  function automatic logic [65:0] model(input logic [31:0] ins, input logic [31:0] pc);
    return {pc, ins[11:7], ins[19:15], ins[24:20], ins[14:12], ctl_of(ins)};
  endfunction

  logic [65:0] obs_b;
  assign obs_b = {out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_regwrite,
                  out_alusrc, out_memwrite, out_memtoreg, out_branch, out_jal,
                  out_jalr, out_auipc, out_lui, out_csr, out_aluctrl[4:0], out_illegal};

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end else begin
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {14'd0, obs_b}, 80'd0);
        end else begin
          e = exp_q.pop_front();
          check("bundle", {14'd0, obs_b}, {14'd0, e});
          if (e[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] ins);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = $urandom;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 80'd0, 80'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit stream_done;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    cycles(3);
    @(negedge clk);
    check("rst_out_valid", {79'd0, out_valid}, 80'd0);
    check("rst_in_ready", {79'd0, in_ready}, 80'd0);
    check("rst_illegal_cnt", {64'd0, illegal_cnt}, 80'd0);
    check("rst_bundle", {14'd0, obs_b}, 80'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {79'd0, in_ready}, 80'd1);
    @(posedge clk); #1;

    // directed decode: addi, sub to x0, mul (1-cycle latency each)
    out_ready = 1'b1;
    send(32'h00500093);
    check("addi_latency", {79'd0, out_valid}, 80'd1);
    send(32'h40208033);
    check("sub_latency", {79'd0, out_valid}, 80'd1);
    send(32'h022081B3);
    cycles(2);
    @(negedge clk);
    check("mul_illegal_cnt", {64'd0, illegal_cnt}, {64'd0, exp_cnt});
    @(posedge clk); #1;

    // backpressure: A to M, B to S, C stalls until downstream resumes
    out_ready = 1'b0;
    send(32'h007302B3);
    send(32'h00812203);
    @(negedge clk);
    check("bp_in_ready_low", {79'd0, in_ready}, 80'd0);
    @(posedge clk); #1;
    fork
      send(32'h00312223);
      begin cycles(3); out_ready = 1'b1; end
    join
    cycles(4);
    @(negedge clk);
    check("bp_drained", exp_q.size(), 80'd0);
    check("bp_in_ready_high", {79'd0, in_ready}, 80'd1);
    @(posedge clk); #1;

    // flush with M and S full and a new instruction offered
    out_ready = 1'b0;
    send(32'h00208063);
    send(32'h000000EF);
    in_valid = 1'b1; in_instr = 32'h12345337; in_pc = $urandom; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {79'd0, out_valid}, 80'd0);
    check("flush_in_ready", {79'd0, in_ready}, 80'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(3);

    // random stream over the whole table with random downstream stalls
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 3 * N_INS; i++) send(ins_tbl[$urandom_range(0, N_INS - 1)]);
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    cycles(4);
    @(negedge clk);
    check("stream_drained", exp_q.size(), 80'd0);
    check("stream_illegal_cnt", {64'd0, illegal_cnt}, {64'd0, exp_cnt});
    @(posedge clk); #1;

    // illegal counter saturation
    for (int i = 0; i < 65537; i++) send(32'h00000000);
    cycles(3);
    @(negedge clk);
    check("sat_illegal_cnt", {64'd0, illegal_cnt}, 80'hFFFF);
    check("sat_model_cnt", {64'd0, illegal_cnt}, {64'd0, exp_cnt});
    @(posedge clk); #1;

    // mid-stream reset drops the held instruction and clears the counter
    out_ready = 1'b0;
    send(32'h00500093);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {79'd0, out_valid}, 80'd0);
    check("midrst_illegal_cnt", {64'd0, illegal_cnt}, 80'd0);
    check("midrst_in_ready", {79'd0, in_ready}, 80'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
